// File: rtl/bit_serializer_pkg.sv
// Shared types and default parameter values for the parallel-to-serial converter.
package bit_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_e;

    localparam int DEFAULT_WIDTH      = 8;
    localparam int DEFAULT_MSB_FIRST  = 1;
    localparam int DEFAULT_GAP_CYCLES = 0;

endpackage

// File: rtl/bit_serializer.sv
// Accepts a parallel word over a valid/ready handshake and streams it out one bit per cycle,
// optionally followed by a fixed number of idle gap cycles.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int MSB_FIRST  = DEFAULT_MSB_FIRST,
    parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             data_out,
    output logic             bit_valid,
    output logic             busy
);

    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [3:0]       LAST_GAP = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    logic             data_out_q, data_out_d;
    logic             bit_valid_q, bit_valid_d;
    logic             last_bit;
    logic             accept;

    function automatic logic first_bit(input logic [WIDTH-1:0] word);
        return (MSB_FIRST != 0) ? word[WIDTH-1] : word[0];
    endfunction

    // The shift register holds the word with the bit currently on data_out in the leading position.
    assign last_bit  = (state_q == SHIFT) && (bit_cnt_q == LAST_BIT);
    assign in_ready  = (state_q == IDLE) || (last_bit && (GAP_CYCLES == 0));
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q != IDLE);
    assign data_out  = data_out_q;
    assign bit_valid = bit_valid_q;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        data_out_d  = 1'b0;
        bit_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = SHIFT;
                    shift_d     = in_data;
                    bit_cnt_d   = '0;
                    data_out_d  = first_bit(in_data);
                    bit_valid_d = 1'b1;
                end
            end
            SHIFT: begin
                if (!last_bit) begin
                    bit_cnt_d   = bit_cnt_q + 1'b1;
                    bit_valid_d = 1'b1;
                    if (MSB_FIRST != 0) begin
                        shift_d    = {shift_q[WIDTH-2:0], 1'b0};
                        data_out_d = shift_q[WIDTH-2];
                    end else begin
                        shift_d    = {1'b0, shift_q[WIDTH-1:1]};
                        data_out_d = shift_q[1];
                    end
                end else if (GAP_CYCLES > 0) begin
                    state_d   = GAP;
                    gap_cnt_d = 4'd0;
                    bit_cnt_d = '0;
                end else if (accept) begin
                    shift_d     = in_data;
                    bit_cnt_d   = '0;
                    data_out_d  = first_bit(in_data);
                    bit_valid_d = 1'b1;
                end else begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end
            end
            GAP: begin
                if (gap_cnt_q == LAST_GAP) begin
                    state_d   = IDLE;
                    gap_cnt_d = 4'd0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= 4'd0;
            data_out_q  <= 1'b0;
            bit_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            data_out_q  <= data_out_d;
            bit_valid_q <= bit_valid_d;
        end
    end

endmodule
